// File: rtl/axis_pkt_pkg.sv
// Shared types and header helpers for the AXI-Stream packetizer.
// Header layout: sync byte [31:24], sequence number [23:16], payload length [15:0].
package axis_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_SEQ_LSB  = 16;
  localparam int HDR_LEN_LSB  = 0;

  function automatic logic [31:0] build_hdr(input logic [7:0]  sync,
                                            input logic [7:0]  seq,
                                            input logic [15:0] len);
    logic [31:0] hdr;
    hdr = (32'(sync) << HDR_SYNC_LSB) |
          (32'(seq)  << HDR_SEQ_LSB)  |
          (32'(len)  << HDR_LEN_LSB);
    return hdr;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single registered AXI-Stream output slot.
// Handshake: a beat transfers on a clock edge where m_axis_tvalid && m_axis_tready; tdata/tlast hold while stalled.
module axis_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  slot_free
);

  assign slot_free = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= load_data;
      m_axis_tlast  <= load_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_packetizer.sv
// Cuts a 32-bit AXI-Stream into fixed-length packets with optional header word and tlast marking.
// Upstream words are only accepted in PAYLOAD, so each packet costs one idle bubble cycle.
module axis_packetizer
  import axis_pkt_pkg::*;
#(
  parameter int         DATA_WIDTH  = 32,
  parameter int         PKT_LEN_MAX = 256,
  parameter int         LEN_WIDTH   = $clog2(PKT_LEN_MAX + 1),
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  cfg_enable,
  input  logic                  cfg_hdr_en,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  output logic                  busy,
  output logic [15:0]           pkt_count,
  output logic [1:0]            dbg_state
);

  state_t                state, state_nx;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt;
  logic [7:0]            seq;
  logic                  slot_free;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  in_hs;
  logic                  is_last;
  logic [LEN_WIDTH-1:0]  len_clamped;

  assign len_clamped = ((cfg_pkt_len == '0) || (cfg_pkt_len > LEN_WIDTH'(PKT_LEN_MAX)))
                       ? LEN_WIDTH'(1) : cfg_pkt_len;

  assign in_hs     = s_axis_tvalid && s_axis_tready;
  assign is_last   = (cnt == (len_q - LEN_WIDTH'(1)));
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nx      = state;
    load          = 1'b0;
    load_data     = '0;
    load_last     = 1'b0;
    s_axis_tready = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_enable && s_axis_tvalid)
          state_nx = cfg_hdr_en ? HEADER : PAYLOAD;
      end
      HEADER: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = DATA_WIDTH'(build_hdr(SYNC_BYTE, seq, 16'(len_q)));
          state_nx  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        s_axis_tready = slot_free;
        if (in_hs) begin
          load      = 1'b1;
          load_data = s_axis_tdata;
          load_last = is_last;
          if (is_last)
            state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state     <= IDLE;
      len_q     <= LEN_WIDTH'(1);
      cnt       <= '0;
      seq       <= '0;
      pkt_count <= '0;
    end else begin
      state <= state_nx;
      // Config is captured only at packet start so mid-packet changes wait for the next one.
      if (state == IDLE && cfg_enable && s_axis_tvalid)
        len_q <= len_clamped;
      if (state == PAYLOAD && in_hs) begin
        if (is_last) begin
          cnt       <= '0;
          seq       <= seq + 8'd1;
          pkt_count <= pkt_count + 16'd1;
        end else begin
          cnt <= cnt + LEN_WIDTH'(1);
        end
      end
    end
  end

  axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk          (axis_clk),
    .rst_n        (axis_rst_n),
    .load         (load),
    .load_data    (load_data),
    .load_last    (load_last),
    .m_axis_tready(m_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .slot_free    (slot_free)
  );

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: source queue driver, output scoreboard, per-scenario tasks.
module tb_axis_packetizer;

  localparam int W = 33;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        cfg_enable = 1'b1;
  logic        cfg_hdr_en = 1'b0;
  logic [8:0]  cfg_pkt_len = 9'd1;
  logic        busy;
  logic [15:0] pkt_count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  src_q[$];
  bit           src_taken = 0;
  bit           held_prev = 0;
  logic [31:0]  prev_data;
  logic         prev_last;
  int           rdy_mode = 0;  // 0 always ready, 1 toggling, 2 random

  always #5 axis_clk = ~axis_clk;

  axis_packetizer dut (
    .axis_clk     (axis_clk),
    .axis_rst_n   (axis_rst_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .cfg_enable   (cfg_enable),
    .cfg_hdr_en   (cfg_hdr_en),
    .cfg_pkt_len  (cfg_pkt_len),
    .busy         (busy),
    .pkt_count    (pkt_count),
    .dbg_state    (dbg_state)
  );

  // One clock of bench activity: monitor at negedge, drive just after posedge.
  task automatic step();
    logic [W-1:0] exp;
    @(negedge axis_clk);
    if (m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got last=%0b data=%08h, required no beat", m_axis_tlast, m_axis_tdata);
      end else begin
        exp = exp_q.pop_front();
        if ({m_axis_tlast, m_axis_tdata} !== exp) begin
          errors++;
          $display("FAIL beat: got last=%0b data=%08h, required last=%0b data=%08h",
                   m_axis_tlast, m_axis_tdata, exp[32], exp[31:0]);
        end
      end
    end
    if (held_prev) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
        errors++;
        $display("FAIL held_stable: got v=%0b last=%0b data=%08h, required v=1 last=%0b data=%08h",
                 m_axis_tvalid, m_axis_tlast, m_axis_tdata, prev_last, prev_data);
      end
    end
    if (m_axis_tvalid && !m_axis_tready) begin
      checks++;
      if (s_axis_tready !== 1'b0) begin
        errors++;
        $display("FAIL s_ready_when_held: got %0b, required 0", s_axis_tready);
      end
    end
    held_prev = m_axis_tvalid && !m_axis_tready;
    prev_data = m_axis_tdata;
    prev_last = m_axis_tlast;
    src_taken = s_axis_tvalid && s_axis_tready;
    @(posedge axis_clk);
    #1;
    if (src_taken && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = src_q[0];
    end else begin
      s_axis_tvalid = 1'b0;
    end
    case (rdy_mode)
      1:       m_axis_tready = ~m_axis_tready;
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b1;
    endcase
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] want);
    checks++;
    if (pkt_count !== want) begin
      errors++;
      $display("FAIL %s_pkt_count: got %0d, required %0d", name, pkt_count, want);
    end
  endtask

  task automatic do_reset();
    @(posedge axis_clk);
    #1;
    axis_rst_n    = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    rdy_mode      = 0;
    src_q.delete();
    exp_q.delete();
    held_prev = 0;
    src_taken = 0;
    repeat (2) @(posedge axis_clk);
    #1;
    axis_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge axis_clk);
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready, busy, pkt_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b d=%08h l=%0b sr=%0b busy=%0b cnt=%0d, required all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready, busy, pkt_count);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d, required 0", dbg_state);
    end
  endtask

  task automatic test_hdr_packets();
    do_reset();
    cfg_hdr_en  = 1'b1;
    cfg_pkt_len = 9'd4;
    for (int i = 1; i <= 8; i++) src_q.push_back(32'(i));
    exp_q.push_back({1'b0, 32'hA500_0004});
    for (int i = 1; i <= 4; i++) exp_q.push_back({(i == 4), 32'(i)});
    exp_q.push_back({1'b0, 32'hA501_0004});
    for (int i = 5; i <= 8; i++) exp_q.push_back({(i == 8), 32'(i)});
    run_until_done(100, "hdr");
    check_cnt("hdr", 16'd2);
  endtask

  task automatic test_no_hdr_len1();
    do_reset();
    cfg_hdr_en  = 1'b0;
    cfg_pkt_len = 9'd1;
    for (int i = 10; i <= 12; i++) begin
      src_q.push_back(32'(i));
      exp_q.push_back({1'b1, 32'(i)});
    end
    run_until_done(50, "nohdr");
    check_cnt("nohdr", 16'd3);
  endtask

  task automatic test_clamp();
    do_reset();
    cfg_hdr_en  = 1'b1;
    cfg_pkt_len = 9'd0;
    src_q.push_back(32'h55);
    exp_q.push_back({1'b0, 32'hA500_0001});
    exp_q.push_back({1'b1, 32'h55});
    run_until_done(30, "clamp0");
    cfg_pkt_len = 9'd300;
    src_q.push_back(32'h66);
    src_q.push_back(32'h67);
    exp_q.push_back({1'b0, 32'hA501_0001});
    exp_q.push_back({1'b1, 32'h66});
    exp_q.push_back({1'b0, 32'hA502_0001});
    exp_q.push_back({1'b1, 32'h67});
    run_until_done(30, "clamp300");
    check_cnt("clamp", 16'd3);
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    cfg_hdr_en  = 1'b0;
    cfg_pkt_len = 9'd8;
    rdy_mode    = 1;
    for (int i = 0; i < 64; i++) begin
      src_q.push_back(32'(i));
      exp_q.push_back({(i % 8 == 7), 32'(i)});
    end
    while (exp_q.size() > 0 && n < 1000) begin
      if (exp_q.size() <= 32) rdy_mode = 2;
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout: got %0d beats outstanding, required 0", exp_q.size());
    end
    rdy_mode = 0;
    repeat (3) step();
    check_cnt("bp", 16'd8);
  endtask

  task automatic test_seq_wrap();
    do_reset();
    cfg_hdr_en  = 1'b1;
    cfg_pkt_len = 9'd1;
    for (int p = 0; p < 257; p++) begin
      src_q.push_back(32'(p) + 32'h1000);
      exp_q.push_back({1'b0, 8'hA5, 8'(p), 16'h0001});
      exp_q.push_back({1'b1, 32'(p) + 32'h1000});
    end
    run_until_done(2000, "wrap");
    check_cnt("wrap", 16'd257);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    cfg_hdr_en  = 1'b1;
    cfg_pkt_len = 9'd4;
    for (int i = 1; i <= 4; i++) src_q.push_back(32'(i));
    exp_q.push_back({1'b0, 32'hA500_0004});
    exp_q.push_back({1'b0, 32'd1});
    exp_q.push_back({1'b0, 32'd2});
    while (exp_q.size() > 0 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_timeout: got %0d beats outstanding, required 0", exp_q.size());
    end
    #2;
    axis_rst_n = 1'b0;
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready, busy, pkt_count} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got v=%0b d=%08h l=%0b sr=%0b busy=%0b cnt=%0d, required all 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready, busy, pkt_count);
    end
    do_reset();
    check_cnt("rstmid_after", 16'd0);
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(32'h70 + 32'(i));
      if (i == 0) exp_q.push_back({1'b0, 32'hA500_0004});
      exp_q.push_back({(i == 3), 32'h70 + 32'(i)});
    end
    run_until_done(50, "rstmid_next");
    check_cnt("rstmid_next", 16'd1);
  endtask

  initial begin
    test_reset();
    test_hdr_packets();
    test_no_hdr_len1();
    test_clamp();
    test_backpressure();
    test_seq_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_packetizer.md
Name: axis_packetizer

Overview:
- Single-clock AXI-Stream framing stage directly downstream of the AXIS data FIFO master port; consumes its 32-bit word stream.
- Cuts the stream into packets of a runtime-programmed length and drives m_axis_tlast on the final beat of each packet.
- Optionally prepends a header word carrying a sync byte, a sequence number and the payload length.
- Output is a registered AXIS master with full throughput; feeds the downstream link/DMA.

Parameters:
- DATA_WIDTH, 32, stream word width; minimum legal value 32; header is zero-extended above bit 31.
- PKT_LEN_MAX, 256, largest payload length in words.
- LEN_WIDTH, $clog2(PKT_LEN_MAX+1) = 9, width of the length config and beat counter.
- SYNC_BYTE, 8'hA5, value placed in header bits [31:24].

Ports:
- axis_clk, in, 1, single clock for all logic.
- axis_rst_n, in, 1, asynchronous active-low reset.
- s_axis_tvalid, in, 1, upstream word valid (from FIFO m_axis_tvalid).
- s_axis_tready, out, 1, upstream ready.
- s_axis_tdata, in, DATA_WIDTH, upstream word.
- m_axis_tvalid, out, 1, output beat valid.
- m_axis_tready, in, 1, downstream ready.
- m_axis_tdata, out, DATA_WIDTH, output beat.
- m_axis_tlast, out, 1, last beat of packet.
- cfg_enable, in, 1, allow new packets to start.
- cfg_hdr_en, in, 1, prepend header word.
- cfg_pkt_len, in, LEN_WIDTH, payload words per packet; 0 or >PKT_LEN_MAX is clamped to 1.
- busy, out, 1, high in HEADER or PAYLOAD.
- pkt_count, out, 16, completed packets; wraps modulo 2^16.

Behaviour:
- Reset (async assert, sync release): state=IDLE; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0; s_axis_tready=0; busy=0; pkt_count=0; seq=0; beat counter=0.
- Output slot: one register; slot_free = !m_axis_tvalid || m_axis_tready.
  - Slot loads on any accepted source beat.
  - m_axis_tvalid drops only when m_axis_tready=1 and nothing new loads.
  - tdata and tlast are held stable while tvalid=1 and tready=0.
- s_axis_tready = slot_free when state==PAYLOAD, else 0. It depends combinationally on m_axis_tready.
- Input handshake = s_axis_tvalid && s_axis_tready.
- FSM:
  - IDLE: if cfg_enable && s_axis_tvalid, latch len (clamped cfg_pkt_len) and hdr_en.
    - Go to HEADER if hdr_en, else PAYLOAD.
    - No data is consumed in IDLE, so there is 1 bubble cycle per packet.
  - HEADER: when slot_free, load tdata = {SYNC_BYTE, seq[7:0], 16'(len)} with tlast=0, then go to PAYLOAD.
  - PAYLOAD: on each input handshake, load tdata=s_axis_tdata and tlast=(cnt==len-1), then cnt++.
    - On the last beat: cnt=0, seq++, pkt_count++, go to IDLE.
- Config (cfg_pkt_len, cfg_hdr_en) is sampled only in IDLE; changes mid-packet affect the next packet only.
- cfg_enable deasserted mid-packet: the current packet completes, and no new packet starts.
- Latency: input word to m_axis_tvalid is 1 cycle. Sustained throughput is 1 word/cycle inside a packet.
- seq is 8 bits and wraps from 255 to 0. pkt_count wraps from 65535 to 0.
- Reset mid-packet: the partial packet is dropped, and the FSM restarts in IDLE with seq=0.
- busy = (state != IDLE).

Decomposition:
- Shared package axis_pkt_pkg holds:
  - state enum {IDLE, HEADER, PAYLOAD};
  - SYNC_BYTE default;
  - header field offsets (SYNC [31:24], SEQ [23:16], LEN [15:0]);
  - function build_hdr(seq, len).
- One natural sub-module, axis_out_reg: the registered output slot producing slot_free. Everything else stays in the top.

Test Plan:
- Header packets: cfg_hdr_en=1, cfg_pkt_len=4, inputs 1..8, m_axis_tready=1 → output sequence 0xA5000004, 1, 2, 3, 4 (tlast), 0xA5010004, 5, 6, 7, 8 (tlast); pkt_count=2.
- No header, length 1: cfg_hdr_en=0, cfg_pkt_len=1, inputs 10, 11, 12 → outputs 10, 11, 12, each with tlast=1; pkt_count=3.
- Clamped length: cfg_pkt_len=0 and, separately, 300 → each packet has exactly 1 payload word; the header LEN field = 0x0001.
- Backpressure: len=8, m_axis_tready toggling 1,0,1,0 and random, inputs 0..63.
  - Scoreboard matches all 64 words in order with no drops or duplicates.
  - tdata and tlast stay stable whenever tvalid=1 and tready=0.
  - s_axis_tready=0 whenever the slot is held.
- Sequence wrap: 257 header packets of len=1 → 256th header SEQ=0xFF, 257th header SEQ=0x00; pkt_count=257.
- Reset mid-packet: len=4, hdr_en=1; assert axis_rst_n=0 after 2 payload beats.
  - All outputs are 0 immediately.
  - After release, the next header is 0xA5000004 and pkt_count=0.
